shift_mult_arb: RTL and testbench
=================================

# shift_mult_arb

Two-port arbiter and sequencer for the shared 16-bit shift-add multiplier (`B_WIDTH`-bit multiplier operand, one partial-product step per falling clock edge).
- Accepts multiply requests from two requesters and grants the multiplier round-robin.
- Drives the multiplier's load/clear strobe and operands, counts exactly `B_WIDTH` accumulate steps, then captures the product into a result register.
- Returns the result on a shared valid/ready result port tagged with the requester ID.
- Sits between the two client blocks and the multiplier instance; it is the only driver of the multiplier's control inputs.

## Interface
- `B_WIDTH`, 8, width of the b operand and number of accumulate steps; legal range 2..16.
- `clk` in 1: single clock. Controller logic is posedge; the multiplier it drives is negedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: request from requester 0/1. Held high with operands stable until the matching grant.
- `a0`, `a1` in 16: a operand for requester 0/1.
- `b0`, `b1` in `B_WIDTH`: b operand for requester 0/1.
- `gnt0`, `gnt1` out 1: one-cycle grant pulse; operands were sampled at this edge.
- `res_valid` out 1: result available; held until accepted.
- `res_ready` in 1: result consumer ready.
- `res_id` out 1: requester that owns `res_y`.
- `res_y` out 16: captured multiplier output.
- `busy` out 1: high in every state except IDLE.
- `mult_rst` out 1: multiplier clear/load strobe (active-high).
- `mult_a` out 16: operand register, to the multiplier's a input.
- `mult_b` out `B_WIDTH`: operand register, to the multiplier's b input.
- `mult_y` in 16: multiplier y output.

## Operation
- States: IDLE, LOAD, RUN, DONE. Step counter `cnt` is `max(1,$clog2(B_WIDTH))` bits wide. Round-robin pointer `last` is 1 bit.
- `mult_rst` is a Moore output: 0 only in RUN, 1 in IDLE, LOAD and DONE. The multiplier therefore stays cleared whenever it is not running.
- **IDLE:**
  - If any `req` is high: select winner, latch its a/b into `mult_a`/`mult_b`, pulse its `gnt`, set `res_id` to the winner, set `last` to the winner, go to LOAD.
  - Arbitration: single request wins directly. If both are high, the winner is the requester that is not `last`.
- **LOAD:** one cycle. The multiplier clears y and latches b on this cycle's falling edge. Next state is RUN with `cnt`=0.
- **RUN:** `B_WIDTH` cycles, each containing one multiplier step on its falling edge. On the posedge where `cnt`=`B_WIDTH`-1:
  - `res_y` <= `mult_y`
  - `res_valid` <= 1
  - go to DONE.
  - Otherwise `cnt` increments.
- **DONE:** hold `res_valid`, `res_y` and `res_id`. At a posedge with `res_ready`=1: clear `res_valid`, go to IDLE. Requests are not sampled in DONE.
- Requests arriving while `busy` are ignored until IDLE. A requester must keep `req` high to be served. A request dropped before its grant is lost, with no error.
- Arithmetic: `res_y` is the multiplier's y after exactly `B_WIDTH` steps. For a < 2^15 this equals floor(a*b / 2^B_WIDTH). No widening or saturation is applied in this block.
- **Reset (`rst_n`=0, any time, including mid-RUN):**
  - State goes to IDLE immediately and `mult_rst` goes to 1 asynchronously.
  - `gnt0`, `gnt1`, `res_valid`, `res_id`, `busy`, `cnt` and `last` are set to 0; `res_y`, `mult_a` and `mult_b` are set to 0.
  - The in-flight operation is discarded and produces no result.

## Timing
- Let grant posedge be edge k (`gnt` high during cycle k..k+1).
  - LOAD is cycle k..k+1.
  - RUN occupies cycles k+1 .. k+`B_WIDTH`+1.
  - `res_valid` rises at edge k+`B_WIDTH`+1.
- Grant-to-result latency: `B_WIDTH`+1 cycles (9 at default).
- With `res_ready` held high: DONE lasts 1 cycle, then 1 IDLE cycle. Back-to-back grants are therefore `B_WIDTH`+3 cycles apart (11 at default).
- Request-to-grant latency from IDLE: 1 edge (a request high before edge k is granted at edge k).
- `mult_a`/`mult_b` are stable from the grant edge until the next grant; they never change in LOAD, RUN or DONE.

## Test plan
- **Single request, default B_WIDTH=8, real multiplier instanced:** `req0` with a=0x1000, b=0x03.
  - `gnt0` pulses once.
  - `res_valid` rises 9 cycles later with `res_y`=0x0030, `res_id`=0.
- **Boundary operand:** `req1` with a=0x0100, b=0xFF.
  - `res_y`=0x00FF, `res_id`=1.
  - b=0x00 gives `res_y`=0x0000.
- **Both requesters held high continuously:**
  - Grants alternate 0,1,0,1 (first tie goes to 0).
  - Grants are 11 cycles apart with `res_ready`=1.
- **Backpressure:** `res_ready`=0 for 20 cycles after `res_valid`.
  - `res_valid`, `res_y` and `res_id` are held.
  - No `gnt` while `req1` is pending.
  - `gnt1` fires 2 edges after `res_ready` rises.
- **Reset mid-RUN:** deassert `rst_n` 4 cycles after the grant.
  - `mult_rst` goes to 1 and `busy` to 0 without waiting for a clock edge.
  - No `res_valid` is produced.
  - After release, a new request completes normally with the correct product.
- **`mult_rst` profile:** check `mult_rst` is 0 for exactly `B_WIDTH` consecutive cycles per operation. Repeat with B_WIDTH=4, a=0x0010, b=0xF, expecting `res_y`=0x000F.

Source files
------------

// File: rtl/shift_mult_arb.sv
// Round-robin arbiter and step sequencer in front of a shared negedge shift-add multiplier.
// Grants one of two requesters, runs B_WIDTH accumulate steps, returns the tagged product.
module shift_mult_arb #(
    parameter int B_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [15:0]        a0,
    input  logic [15:0]        a1,
    input  logic [B_WIDTH-1:0] b0,
    input  logic [B_WIDTH-1:0] b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [15:0]        res_y,
    output logic               busy,
    output logic               mult_rst,
    output logic [15:0]        mult_a,
    output logic [B_WIDTH-1:0] mult_b,
    input  logic [15:0]        mult_y
);

    localparam int CW = (B_WIDTH > 2) ? $clog2(B_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic                 last_r;
    logic                 gnt0_r;
    logic                 gnt1_r;
    logic                 res_valid_r;
    logic                 res_id_r;
    logic [15:0]          res_y_r;
    logic                 busy_r;
    logic                 mult_rst_r;
    logic [15:0]          mult_a_r;
    logic [B_WIDTH-1:0]   mult_b_r;
    logic                 any_req_s;
    logic                 win_s;

    // Winner selection: a lone request wins, a tie goes to whoever was not served last
    always_comb begin
        any_req_s = req0 | req1;
        win_s     = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Sequencer: grant, load, count steps, hold the result until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            last_r      <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= 1'b0;
            res_y_r     <= 16'h0000;
            busy_r      <= 1'b0;
            mult_rst_r  <= 1'b1;
            mult_a_r    <= 16'h0000;
            mult_b_r    <= {B_WIDTH{1'b0}};
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    mult_rst_r <= 1'b1;
                    if (any_req_s) begin
                        state_r  <= LOAD;
                        busy_r   <= 1'b1;
                        gnt0_r   <= ~win_s;
                        gnt1_r   <= win_s;
                        res_id_r <= win_s;
                        last_r   <= win_s;
                        mult_a_r <= win_s ? a1 : a0;
                        mult_b_r <= win_s ? b1 : b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r    <= RUN;
                    cnt_r      <= {CW{1'b0}};
                    mult_rst_r <= 1'b0;
                end
                RUN: begin
                    // mult_y is sampled after the last falling-edge step of this cycle
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DONE;
                        res_y_r     <= mult_y;
                        res_valid_r <= 1'b1;
                        mult_rst_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    mult_rst_r  <= 1'b1;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_y     = res_y_r;
    assign busy      = busy_r;
    assign mult_rst  = mult_rst_r;
    assign mult_a    = mult_a_r;
    assign mult_b    = mult_b_r;

endmodule

// File: tb/tb_shift_mult_arb.sv
// Bench for shift_mult_arb: transaction-level reference model checked every cycle,
// directed literal checks, randomized traffic, and a small B_WIDTH=4 instance.
module tb_shift_mult_arb;

    localparam int B8 = 8;
    localparam int B4 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, B_WIDTH = 8
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = 16'h0, a1 = 16'h0;
    logic [7:0]  b0 = 8'h0, b1 = 8'h0;
    logic        res_ready = 1'b1;
    logic        gnt0, gnt1, res_valid, res_id, busy, mult_rst;
    logic [15:0] res_y, mult_a, mult_y;
    logic [7:0]  mult_b;
    logic [7:0]  mb_sh;

    shift_mult_arb #(.B_WIDTH(B8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_y(res_y), .busy(busy), .mult_rst(mult_rst),
        .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y)
    );

    // Shift-add multiplier: clear/load while mult_rst, else one step per falling edge
    always @(negedge clk) begin
        if (mult_rst) begin
            mult_y <= 16'h0;
            mb_sh  <= mult_b;
        end else begin
            mult_y <= 16'(({1'b0, mult_y} + (mb_sh[0] ? {1'b0, mult_a} : 17'h0)) >> 1);
            mb_sh  <= mb_sh >> 1;
        end
    end

    // Second instance, B_WIDTH = 4
    logic        s4_req0 = 1'b0, s4_req1 = 1'b0;
    logic [15:0] s4_a0 = 16'h0, s4_a1 = 16'h0;
    logic [3:0]  s4_b0 = 4'h0, s4_b1 = 4'h0;
    logic        s4_ready = 1'b1;
    logic        s4_gnt0, s4_gnt1, s4_valid, s4_id, s4_busy, s4_mrst;
    logic [15:0] s4_y, s4_ma, s4_my;
    logic [3:0]  s4_mb, s4_sh;

    shift_mult_arb #(.B_WIDTH(B4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(s4_req0), .req1(s4_req1), .a0(s4_a0), .a1(s4_a1), .b0(s4_b0), .b1(s4_b1),
        .gnt0(s4_gnt0), .gnt1(s4_gnt1), .res_valid(s4_valid), .res_ready(s4_ready),
        .res_id(s4_id), .res_y(s4_y), .busy(s4_busy), .mult_rst(s4_mrst),
        .mult_a(s4_ma), .mult_b(s4_mb), .mult_y(s4_my)
    );

    always @(negedge clk) begin
        if (s4_mrst) begin
            s4_my <= 16'h0;
            s4_sh <= s4_mb;
        end else begin
            s4_my <= 16'(({1'b0, s4_my} + (s4_sh[0] ? {1'b0, s4_ma} : 17'h0)) >> 1);
            s4_sh <= s4_sh >> 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s @cyc %0d: got timeout expected event", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_g8(input bit which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((which ? gnt1 : gnt0) == 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) timeout("wait_gnt");
    endtask

    task automatic wait_v8(input int budget, output int at, output int lowc, output int gc);
        at = -1; lowc = 0; gc = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!mult_rst) lowc++;
            if (gnt0 || gnt1) gc++;
            if (res_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) timeout("wait_valid");
    endtask

    // Reference model: a transaction timeline (idle / t edges since grant / result pending)
    bit          m_idle, m_valid, m_gnt0, m_gnt1, m_id, m_last;
    int          m_t, m_prod;
    logic [15:0] m_a, m_y;
    logic [7:0]  m_b;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_idle = 1'b1; m_valid = 1'b0; m_gnt0 = 1'b0; m_gnt1 = 1'b0;
                m_id = 1'b0; m_last = 1'b0; m_t = 0; m_prod = 0;
                m_a = 16'h0; m_b = 8'h0; m_y = 16'h0;
            end else begin
                m_gnt0 = 1'b0;
                m_gnt1 = 1'b0;
                if (m_idle) begin
                    if (req0 || req1) begin
                        m_id   = (req0 && req1) ? !m_last : req1;
                        m_last = m_id;
                        m_gnt0 = !m_id;
                        m_gnt1 = m_id;
                        m_a    = m_id ? a1 : a0;
                        m_b    = m_id ? b1 : b0;
                        m_prod = (int'(m_a) * int'(m_b)) / (1 << B8);
                        m_idle = 1'b0;
                        m_t    = 0;
                    end
                end else if (m_valid) begin
                    if (res_ready) begin
                        m_valid = 1'b0;
                        m_idle  = 1'b1;
                    end
                end else begin
                    m_t++;
                    if (m_t == B8 + 1) begin
                        m_valid = 1'b1;
                        m_y     = m_prod[15:0];
                    end
                end
            end
            #1;
            chk("m_gnt0", gnt0, m_gnt0);
            chk("m_gnt1", gnt1, m_gnt1);
            chk("m_busy", busy, !m_idle);
            chk("m_mult_rst", mult_rst, (m_idle || m_valid || m_t == 0));
            chk("m_res_valid", res_valid, m_valid);
            chk("m_res_id", res_id, m_id);
            chk("m_res_y", res_y, m_y);
            chk("m_mult_a", mult_a, m_a);
            chk("m_mult_b", mult_b, m_b);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k, at, lowc, gc, nv, sid;
        int g_id[4];
        int g_at[4];
        int ng;
        logic [15:0] sy;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mult_rst", mult_rst, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_y", res_y, 16'h0);
        chk("rst_mult_a", mult_a, 16'h0);
        chk("rst_mult_b", mult_b, 8'h0);
        chk("rst4_mult_rst", s4_mrst, 1'b1);
        rst_n = 1'b1;

        // Single request from 0
        a0 = 16'h1000; b0 = 8'h03; req0 = 1'b1;
        wait_g8(1'b0, 20, k);
        req0 = 1'b0;
        wait_v8(20, at, lowc, gc);
        chk("t1_latency", at - k, 9);
        chk("t1_y", res_y, 16'h0030);
        chk("t1_id", res_id, 1'b0);
        chk("t1_mult_rst_low", lowc, 8);
        chk("t1_extra_gnt", gc, 0);

        // Boundary operands from 1
        a1 = 16'h0100; b1 = 8'hFF; req1 = 1'b1;
        wait_g8(1'b1, 20, k);
        req1 = 1'b0;
        wait_v8(20, at, lowc, gc);
        chk("t2_latency", at - k, 9);
        chk("t2_y", res_y, 16'h00FF);
        chk("t2_id", res_id, 1'b1);
        a1 = 16'h0123; b1 = 8'h00; req1 = 1'b1;
        wait_g8(1'b1, 20, k);
        req1 = 1'b0;
        wait_v8(20, at, lowc, gc);
        chk("t3_y", res_y, 16'h0000);

        // Both held high: alternation and spacing
        a0 = 16'h0555; b0 = 8'h5A; a1 = 16'h7FFF; b1 = 8'hFF;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            step();
            if (gnt0 || gnt1) begin
                g_id[ng] = gnt1 ? 1 : 0;
                g_at[ng] = cyc;
                ng++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (ng < 4) begin
            timeout("t4_grants");
        end else begin
            for (int i = 0; i < 4; i++) chk("t4_order", g_id[i], i % 2);
            for (int i = 1; i < 4; i++) chk("t4_spacing", g_at[i] - g_at[i-1], 11);
        end
        wait_v8(20, at, lowc, gc);

        // Backpressure with a pending request from 1
        a0 = 16'h0400; b0 = 8'h40; req0 = 1'b1;
        wait_g8(1'b0, 20, k);
        req0 = 1'b0;
        a1 = 16'h1234; b1 = 8'h77; req1 = 1'b1;
        wait_v8(20, at, lowc, gc);
        res_ready = 1'b0;
        sy = res_y; sid = res_id;
        chk("t5_y", res_y, 16'h0100);
        chk("t5_id", res_id, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_hold_valid", res_valid, 1'b1);
            chk("t5_hold_y", res_y, sy);
            chk("t5_hold_id", res_id, sid);
            chk("t5_no_gnt", {gnt0, gnt1}, 2'b00);
        end
        res_ready = 1'b1;
        step();
        chk("t5_gnt1_edge1", gnt1, 1'b0);
        step();
        chk("t5_gnt1_edge2", gnt1, 1'b1);
        req1 = 1'b0;
        wait_v8(20, at, lowc, gc);
        chk("t5_y2", res_y, 16'h0876);
        chk("t5_id2", res_id, 1'b1);

        // Reset in the middle of RUN
        a0 = 16'h0800; b0 = 8'h10; req0 = 1'b1;
        wait_g8(1'b0, 20, k);
        req0 = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("t6_mult_rst_async", mult_rst, 1'b1);
        chk("t6_busy_async", busy, 1'b0);
        chk("t6_valid_async", res_valid, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (res_valid) nv++;
        end
        chk("t6_no_result", nv, 0);
        a1 = 16'h0200; b1 = 8'h81; req1 = 1'b1;
        wait_g8(1'b1, 20, k);
        req1 = 1'b0;
        wait_v8(20, at, lowc, gc);
        chk("t6_latency", at - k, 9);
        chk("t6_y", res_y, 16'h0102);
        chk("t6_id", res_id, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            step();
            if (gnt0) begin
                if ($urandom_range(0, 1) == 0) req0 = 1'b0;
                else begin a0 = 16'($urandom_range(0, 32767)); b0 = 8'($urandom); end
            end else if (req0) begin
                if ($urandom_range(0, 31) == 0) req0 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req0 = 1'b1; a0 = 16'($urandom_range(0, 32767)); b0 = 8'($urandom);
            end
            if (gnt1) begin
                if ($urandom_range(0, 1) == 0) req1 = 1'b0;
                else begin a1 = 16'($urandom_range(0, 32767)); b1 = 8'($urandom); end
            end else if (req1) begin
                if ($urandom_range(0, 31) == 0) req1 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req1 = 1'b1; a1 = 16'($urandom_range(0, 32767)); b1 = 8'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        repeat (15) step();

        // B_WIDTH = 4 instance
        s4_a0 = 16'h0010; s4_b0 = 4'hF; s4_req0 = 1'b1;
        k = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s4_gnt0) begin k = cyc; break; end
        end
        if (k < 0) timeout("t8_gnt");
        s4_req0 = 1'b0;
        chk("t8_mult_a", s4_ma, 16'h0010);
        chk("t8_busy", s4_busy, 1'b1);
        at = -1; lowc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!s4_mrst) lowc++;
            if (s4_gnt1) timeout("t8_spurious_gnt1");
            if (s4_valid) begin at = cyc; break; end
        end
        if (at < 0) timeout("t8_valid");
        chk("t8_latency", at - k, 5);
        chk("t8_mult_rst_low", lowc, 4);
        chk("t8_y", s4_y, 16'h000F);
        chk("t8_id", s4_id, 1'b0);
        step();
        chk("t8_done_exit", s4_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
